deco_corriente_bcd: RTL and testbench

//  Sequential, parametrised binary-to-BCD decoder for the current/duty readouts of the PWM display path.

---
 rtl/deco_corriente_bcd.sv | 147 ++++++++++++++
 tb/tb_deco_corriente_bcd.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/deco_corriente_bcd.sv
// rtl/deco_corriente_bcd.sv - sequential double-dabble binary-to-BCD decoder with saturation and blanking
module deco_corriente_bcd #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   valor,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   bin_q, bin_d;
    logic [BW-1:0]         work_q, work_d;
    logic                  ovf_acc_q, ovf_acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bcd_q, bcd_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [BW-1:0]         adj;
    logic [BW-1:0]         work_shift;
    logic [IN_WIDTH-1:0]   bin_shift;
    logic                  ovf_next;
    logic                  last_bit;

    // blank[k] is set when digit k and every digit above it are zero; digit 0 is never dark
    function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] v, input logic ovf);
        logic upper_zero;
        blank_of = '0;
        if (BLANK_LZ != 0 && !ovf) begin
            upper_zero = 1'b1;
            for (int k = DIGITS - 1; k >= 1; k--) begin
                upper_zero  = upper_zero && (v[4*k +: 4] == 4'd0);
                blank_of[k] = upper_zero;
            end
        end
    endfunction

    always_comb begin
        adj = work_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (work_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
            end
        end
        work_shift = {adj[BW-2:0], bin_q[IN_WIDTH-1]};
        bin_shift  = bin_q << 1;
        ovf_next   = ovf_acc_q | adj[BW-1];
        last_bit   = (cnt_q == CW'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            work_q     <= '0;
            ovf_acc_q  <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            blank_q    <= blank_of('0, 1'b0);
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            ovf_acc_q  <= ovf_acc_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result registers load on the final shift so they are valid in the same cycle as done
    always_comb begin
        bin_d      = bin_q;
        work_d     = work_q;
        ovf_acc_d  = ovf_acc_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d     = valor;
                    work_d    = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CW'(IN_WIDTH);
                end
            end
            S_SHIFT: begin
                bin_d     = bin_shift;
                work_d    = work_shift;
                ovf_acc_d = ovf_next;
                cnt_d     = cnt_q - CW'(1);
                if (last_bit) begin
                    overflow_d = ovf_next;
                    bcd_d      = ovf_next ? {DIGITS{4'h9}} : work_shift;
                    blank_d    = blank_of(bcd_d, ovf_next);
                end
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign blank    = blank_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_deco_corriente_bcd.sv
// tb/tb_deco_corriente_bcd.sv - directed and random checks of deco_corriente_bcd
module tb_deco_corriente_bcd;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] valor = '0;

    logic        busy0, done0, ovf0;
    logic [15:0] bcd0;
    logic [3:0]  blank0;
    logic        busy1, done1, ovf1;
    logic [7:0]  bcd1;
    logic [1:0]  blank1;
    logic        busy2, done2, ovf2;
    logic [11:0] bcd2;
    logic [2:0]  blank2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] busy_hist, done_hist;
    logic [15:0] bcd_mid;
    int          d1_cnt, d2_cnt;

    always #5 clk = ~clk;

    deco_corriente_bcd #(.IN_WIDTH(8), .DIGITS(4), .BLANK_LZ(1)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start), .valor(valor[7:0]),
        .busy(busy0), .done(done0), .bcd(bcd0), .blank(blank0), .overflow(ovf0));

    deco_corriente_bcd #(.IN_WIDTH(8), .DIGITS(2), .BLANK_LZ(1)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start), .valor(valor[7:0]),
        .busy(busy1), .done(done1), .bcd(bcd1), .blank(blank1), .overflow(ovf1));

    deco_corriente_bcd #(.IN_WIDTH(12), .DIGITS(3), .BLANK_LZ(0)) u2 (
        .clk(clk), .reset_n(reset_n), .start(start), .valor(valor),
        .busy(busy2), .done(done2), .bcd(bcd2), .blank(blank2), .overflow(ovf2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lim_of(input int nd);
        int lim = 1;
        for (int k = 0; k < nd; k++) lim *= 10;
        return lim;
    endfunction

    function automatic logic [15:0] ref_bcd(input int v, input int nd);
        logic [15:0] r = '0;
        int          x = v;
        for (int k = 0; k < nd; k++) begin
            if (v >= lim_of(nd)) r[4*k +: 4] = 4'd9;
            else begin
                r[4*k +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_blank(input int v, input int nd, input bit lz);
        logic [3:0] b = '0;
        if (lz && v < lim_of(nd)) begin
            for (int k = 1; k < nd; k++) if (v < lim_of(k)) b[k] = 1'b1;
        end
        return b;
    endfunction

    // Start one conversion and log busy/done of u0 for 16 cycles; poke retriggers mid-conversion
    task automatic convert(input logic [11:0] v, input bit poke);
        @(negedge clk);
        valor = v;
        start = 1'b1;
        busy_hist = '0;
        done_hist = '0;
        d1_cnt = 0;
        d2_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            busy_hist[i] = busy0;
            done_hist[i] = done0;
            if (done1) d1_cnt++;
            if (done2) d2_cnt++;
            if (i == 8) bcd_mid = bcd0;
            if (i == 1) start = 1'b0;
            if (poke && i == 3) begin
                start = 1'b1;
                valor = 12'd456;
            end
            if (poke && i == 4) start = 1'b0;
        end
        check("u0_one_done", $countones(done_hist), 1);
        check("u1_one_done", d1_cnt, 1);
        check("u2_one_done", d2_cnt, 1);
        check("u2_idle", {31'd0, busy2 | busy1}, 0);
    endtask

    initial begin
        int pos[4];
        int npos;
        int dcount;
        logic [11:0] rv;

        repeat (2) @(negedge clk);
        check("rst_bcd", bcd0, 16'h0000);
        check("rst_blank", blank0, 4'b1110);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_blank_u2", blank2, 3'b000);
        reset_n = 1'b1;

        convert(12'd10, 1'b0);
        check("lat_busy", busy_hist, 17'h003FE);
        check("lat_done", done_hist, 17'h00200);
        check("v10_bcd", bcd0, 16'h0010);
        check("v10_blank", blank0, 4'b1100);
        check("v10_ovf", ovf0, 0);

        convert(12'd255, 1'b0);
        check("v255_bcd", bcd0, 16'h0255);
        check("v255_blank", blank0, 4'b1000);
        convert(12'd0, 1'b0);
        check("v0_bcd", bcd0, 16'h0000);
        check("v0_blank", blank0, 4'b1110);

        convert(12'd200, 1'b0);
        check("d2_200_bcd", bcd1, 8'h99);
        check("d2_200_ovf", ovf1, 1);
        check("d2_200_blank", blank1, 2'b00);
        check("d4_200_bcd", bcd0, 16'h0200);
        convert(12'd7, 1'b0);
        check("d2_7_bcd", bcd1, 8'h07);
        check("d2_7_ovf", ovf1, 0);
        check("d2_7_blank", blank1, 2'b10);

        convert(12'd123, 1'b1);
        check("ign_bcd", bcd0, 16'h0123);
        check("ign_hold", bcd_mid, 16'h0007);
        check("ign_u2", bcd2, 12'h123);

        @(negedge clk);
        valor = 12'd50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_bcd", bcd0, 16'h0000);
        check("abort_blank", blank0, 4'b1110);
        check("abort_busy", busy0, 0);
        check("abort_done", done0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done0) dcount++;
        end
        check("abort_no_done", dcount, 0);
        convert(12'd99, 1'b0);
        check("v99_bcd", bcd0, 16'h0099);

        @(negedge clk);
        start = 1'b1;
        npos = 0;
        for (int i = 0; i < 4; i++) pos[i] = -100;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done0 && npos < 4) begin
                pos[npos] = i;
                npos++;
            end
        end
        start = 1'b0;
        check("b2b_count", npos, 4);
        check("b2b_gap1", pos[1] - pos[0], 10);
        check("b2b_gap2", pos[2] - pos[1], 10);
        repeat (20) @(negedge clk);

        convert(12'd4095, 1'b0);
        check("u2_4095_bcd", bcd2, 12'h999);
        check("u2_4095_ovf", ovf2, 1);

        for (int n = 0; n < 10; n++) begin
            rv = 12'($urandom_range(0, 4095));
            convert(rv, 1'b0);
            check("rnd_u0_bcd", bcd0, ref_bcd(int'(rv[7:0]), 4));
            check("rnd_u0_blank", blank0, ref_blank(int'(rv[7:0]), 4, 1'b1));
            check("rnd_u0_ovf", ovf0, 0);
            check("rnd_u1_bcd", bcd1, ref_bcd(int'(rv[7:0]), 2));
            check("rnd_u1_blank", blank1, ref_blank(int'(rv[7:0]), 2, 1'b1));
            check("rnd_u1_ovf", ovf1, (int'(rv[7:0]) >= 100) ? 1 : 0);
            check("rnd_u2_bcd", bcd2, ref_bcd(int'(rv), 3));
            check("rnd_u2_blank", blank2, 0);
            check("rnd_u2_ovf", ovf2, (int'(rv) >= 1000) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
